// File: rtl/miter_divergence_tracker.sv
// Watches the masked state vectors of both miter instances and records whether,
// when and in which bit groups they first diverge after the victim access.
module miter_divergence_tracker #(
  parameter  int W      = 64,
  parameter  int GROUPS = 8,
  parameter  int DEPTH  = 8,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm_i,
  input  logic              victim_access_i,
  input  logic [W-1:0]      state_a_i,
  input  logic [W-1:0]      state_b_i,
  input  logic [W-1:0]      mask_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              diverged_o,
  output logic              precond_fail_o,
  output logic [CW-1:0]     first_cycle_o,
  output logic [GROUPS-1:0] first_groups_o,
  output logic [GROUPS-1:0] group_sticky_o
);

  localparam int          GW      = W / GROUPS;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                div_reg, div_next;
  logic                pre_reg, pre_next;
  logic [CW-1:0]       first_cycle_reg, first_cycle_next;
  logic [GROUPS-1:0]   first_groups_reg, first_groups_next;
  logic [GROUPS-1:0]   sticky_reg, sticky_next;

  logic [W-1:0]        diff;
  logic [GROUPS-1:0]   grp;

  assign diff = (state_a_i ^ state_b_i) & ~mask_i;

  generate
    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_group
      assign grp[gi] = |diff[gi*GW +: GW];
    end
  endgenerate

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    div_next          = div_reg;
    pre_next          = pre_reg;
    first_cycle_next  = first_cycle_reg;
    first_groups_next = first_groups_reg;
    sticky_next       = sticky_reg;
    case (state_reg)
      IDLE, DONE: begin
        // An arm always wins over a simultaneous trigger; the trigger is dropped.
        if (arm_i) begin
          state_next        = ARMED;
          cnt_next          = '0;
          div_next          = 1'b0;
          pre_next          = 1'b0;
          first_cycle_next  = '0;
          first_groups_next = '0;
          sticky_next       = '0;
        end
      end
      ARMED: begin
        if (victim_access_i) begin
          if (|grp) begin
            state_next        = DONE;
            pre_next          = 1'b1;
            div_next          = 1'b1;
            first_cycle_next  = '0;
            first_groups_next = grp;
            sticky_next       = grp;
          end else begin
            state_next = TRACK;
            cnt_next   = CW'(1);
          end
        end
      end
      TRACK: begin
        if (|grp) begin
          sticky_next = sticky_reg | grp;
          if (!div_reg) begin
            div_next          = 1'b1;
            first_cycle_next  = cnt_reg;
            first_groups_next = grp;
          end
        end
        if (cnt_reg == DEPTH_C) state_next = DONE;
        else                    cnt_next   = cnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == ARMED) || (state_next == TRACK);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      div_reg          <= 1'b0;
      pre_reg          <= 1'b0;
      first_cycle_reg  <= '0;
      first_groups_reg <= '0;
      sticky_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      div_reg          <= div_next;
      pre_reg          <= pre_next;
      first_cycle_reg  <= first_cycle_next;
      first_groups_reg <= first_groups_next;
      sticky_reg       <= sticky_next;
    end
  end

  assign busy_o         = busy_reg;
  assign done_o         = done_reg;
  assign diverged_o     = div_reg;
  assign precond_fail_o = pre_reg;
  assign first_cycle_o  = first_cycle_reg;
  assign first_groups_o = first_groups_reg;
  assign group_sticky_o = sticky_reg;

endmodule

// File: tb/tb_miter_divergence_tracker.sv
// Directed bench for miter_divergence_tracker: hand-computed expectations for
// divergence timing, group reporting, masking, precondition and control edges.
module tb_miter_divergence_tracker;

  localparam int W = 64;
  localparam int GROUPS = 8;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              arm_i = 1'b0;
  logic              victim_access_i = 1'b0;
  logic [W-1:0]      state_a_i = '0;
  logic [W-1:0]      state_b_i = '0;
  logic [W-1:0]      mask_i = '0;
  logic              busy_o, done_o, diverged_o, precond_fail_o;
  logic [CW-1:0]     first_cycle_o;
  logic [GROUPS-1:0] first_groups_o, group_sticky_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] cmp_diff [0:DEPTH];

  miter_divergence_tracker #(.W(W), .GROUPS(GROUPS), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .arm_i(arm_i), .victim_access_i(victim_access_i),
    .state_a_i(state_a_i), .state_b_i(state_b_i), .mask_i(mask_i),
    .busy_o(busy_o), .done_o(done_o), .diverged_o(diverged_o),
    .precond_fail_o(precond_fail_o), .first_cycle_o(first_cycle_o),
    .first_groups_o(first_groups_o), .group_sticky_o(group_sticky_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Drive one cycle's inputs, clock it, then settle past the edge.
  task automatic do_cycle(input logic arm, input logic vic, input logic [W-1:0] d);
    arm_i = arm;
    victim_access_i = vic;
    state_a_i = {$urandom, $urandom};
    state_b_i = state_a_i ^ d;
    @(posedge clock);
    #1;
  endtask

  task automatic check_results(input string tag, input logic dn, input logic dv,
                               input logic pf, input logic [CW-1:0] fc,
                               input logic [GROUPS-1:0] fg, input logic [GROUPS-1:0] sg);
    check({tag, ".done"}, 64'(done_o), 64'(dn));
    check({tag, ".diverged"}, 64'(diverged_o), 64'(dv));
    check({tag, ".precond"}, 64'(precond_fail_o), 64'(pf));
    check({tag, ".first_cycle"}, 64'(first_cycle_o), 64'(fc));
    check({tag, ".first_groups"}, 64'(first_groups_o), 64'(fg));
    check({tag, ".sticky"}, 64'(group_sticky_o), 64'(sg));
  endtask

  // Arm, trigger with cmp_diff[0], then run all compare cycles with cmp_diff[k].
  task automatic run_window(input string tag, input logic arm_during);
    do_cycle(1'b1, 1'b0, '0);
    check({tag, ".busy_after_arm"}, 64'(busy_o), 64'd1);
    do_cycle(1'b0, 1'b1, cmp_diff[0]);
    check({tag, ".busy_after_trig"}, 64'(busy_o), 64'd1);
    for (int k = 1; k <= DEPTH; k++) begin
      do_cycle(arm_during, 1'b0, cmp_diff[k]);
      if (k == DEPTH - 1) check({tag, ".not_done_early"}, 64'(done_o), 64'd0);
    end
    check({tag, ".busy_end"}, 64'(busy_o), 64'd0);
  endtask

  task automatic clear_diffs();
    for (int k = 0; k <= DEPTH; k++) cmp_diff[k] = '0;
  endtask

  initial begin
    #12;
    check_results("reset", 1'b0, 1'b0, 1'b0, '0, '0, '0);
    check("reset.busy", 64'(busy_o), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;

    // Simultaneous arm and trigger in IDLE: only the arm counts.
    do_cycle(1'b1, 1'b1, 64'h1);
    check("idle_arm_trig.busy", 64'(busy_o), 64'd1);
    check("idle_arm_trig.precond", 64'(precond_fail_o), 64'd0);
    check("idle_arm_trig.done", 64'(done_o), 64'd0);

    clear_diffs();
    run_window("equal", 1'b0);
    check_results("equal", 1'b1, 1'b0, 1'b0, '0, '0, '0);

    clear_diffs();
    cmp_diff[3] = 64'h1 << 17;
    run_window("grp2", 1'b0);
    check_results("grp2", 1'b1, 1'b1, 1'b0, CW'(3), 8'h04, 8'h04);

    clear_diffs();
    cmp_diff[2] = 64'h1;
    cmp_diff[5] = 64'h1 << 63;
    run_window("two_events", 1'b0);
    check_results("two_events", 1'b1, 1'b1, 1'b0, CW'(2), 8'h01, 8'h81);

    clear_diffs();
    cmp_diff[0] = 64'h1 << 40;
    mask_i = 64'h1 << 40;
    run_window("masked_trig", 1'b0);
    check_results("masked_trig", 1'b1, 1'b0, 1'b0, '0, '0, '0);
    mask_i = '0;

    // Precondition failure: done one cycle after the trigger.
    do_cycle(1'b1, 1'b0, '0);
    do_cycle(1'b0, 1'b1, 64'h1 << 40);
    check_results("precond", 1'b1, 1'b1, 1'b1, '0, 8'h20, 8'h20);
    check("precond.busy", 64'(busy_o), 64'd0);

    // Re-arm in DONE with a simultaneous trigger: results clear, trigger lost.
    do_cycle(1'b1, 1'b1, '0);
    check("rearm.busy", 64'(busy_o), 64'd1);
    check_results("rearm", 1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int k = 0; k < DEPTH + 2; k++) do_cycle(1'b0, 1'b0, 64'hFF);
    check("rearm.still_armed", 64'(busy_o), 64'd1);
    check("rearm.no_done", 64'(done_o), 64'd0);
    do_cycle(1'b0, 1'b1, 64'h1 << 8);
    check_results("rearm_trig", 1'b1, 1'b1, 1'b1, '0, 8'h02, 8'h02);

    // arm_i held high through TRACK must not restart the window.
    clear_diffs();
    cmp_diff[4] = 64'h1 << 30;
    run_window("arm_in_track", 1'b1);
    check_results("arm_in_track", 1'b1, 1'b1, 1'b0, CW'(4), 8'h08, 8'h08);

    // Reset asserted at compare cycle 4 after a divergence at cycle 2.
    do_cycle(1'b1, 1'b0, '0);
    do_cycle(1'b0, 1'b1, '0);
    for (int k = 1; k <= 3; k++) do_cycle(1'b0, 1'b0, (k == 2) ? 64'h1 << 50 : 64'h0);
    check("pre_reset.diverged", 64'(diverged_o), 64'd1);
    reset = 1'b1;
    #1;
    check_results("mid_reset", 1'b0, 1'b0, 1'b0, '0, '0, '0);
    check("mid_reset.busy", 64'(busy_o), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;

    // Trigger in IDLE has no effect.
    do_cycle(1'b0, 1'b1, 64'h1);
    check("idle_trig.busy", 64'(busy_o), 64'd0);
    check_results("idle_trig", 1'b0, 1'b0, 1'b0, '0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
